// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fwd_pkg
// Purpose  : Shared types and helpers for the forwarding / hazard controller:
//            controller FSM state encoding, operand-select width helper and
//            the "read from register file" select code.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    // Controller states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } fsm_state_e;

    // Operand select code meaning "take the register-file value"
    localparam int FWD_SEL_RF = 0;

    // Width of one operand select: code 0 plus one code per forwarding stage
    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_sel_prio.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel_prio
// Purpose  : Priority match of one EX source register against all in-flight
//            write stages. The youngest (lowest-index) matching stage wins;
//            register 0 never forwards.
// Ports    : src_addr      in  AW           source register of the EX operand
//            stg_reg_write in  FWD_STAGES   per-stage write enable
//            stg_dest      in  FWD_STAGES*AW per-stage destination register
//            sel           out SW           0 = regfile, k = stage k-1
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_prio
    import fwd_pkg::*;
#(
    parameter int AW         = 5,
    parameter int FWD_STAGES = 2,
    parameter int SW         = sel_width(FWD_STAGES)
) (
    input  logic [AW-1:0]            src_addr,
    input  logic [FWD_STAGES-1:0]    stg_reg_write,
    input  logic [FWD_STAGES*AW-1:0] stg_dest,
    output logic [SW-1:0]            sel
);

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        sel = SW'(FWD_SEL_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stg_reg_write[k] &&
                (stg_dest[k*AW +: AW] != '0) &&
                (stg_dest[k*AW +: AW] == src_addr)) begin
                sel = SW'(k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Purpose  : Forwarding and hazard controller for the pipelined MIPS core.
//            Selects EX operand sources, inserts load-use bubbles, freezes
//            the pipeline while data memory is busy (with a sticky timeout)
//            and counts stalled cycles.
// Ports    : clk, reset        clock / synchronous active-high reset
//            id_src_addr/used  sources of the instruction in ID
//            ex_src_addr       sources of the instruction in EX
//            stg_reg_write     per-stage write enable of in-flight writers
//            stg_dest          per-stage destination register
//            ex_mem_read/dest  load indication and destination in EX
//            me_mem_req        MEM stage data-memory request
//            dmem_ready        data memory completes this cycle
//            fwd_sel           per-operand select, 0 = regfile, k = stage k-1
//            stall_front       hold PC and IF/ID
//            bubble_idex       load NOP into ID/EX
//            stall_all         freeze all pipeline registers
//            mem_timeout       sticky memory-wait timeout flag
//            stall_count       saturating count of stalled cycles
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int AW             = 5,
    parameter int NUM_SRC        = 2,
    parameter int FWD_STAGES     = 2,
    parameter int LOAD_FWD_STAGE = 1,
    parameter int TIMEOUT        = 255,
    parameter int CNT_W          = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_SRC*AW-1:0]                     id_src_addr,
    input  logic [NUM_SRC-1:0]                        id_src_used,
    input  logic [NUM_SRC*AW-1:0]                     ex_src_addr,
    input  logic [FWD_STAGES-1:0]                     stg_reg_write,
    input  logic [FWD_STAGES*AW-1:0]                  stg_dest,
    input  logic                                      ex_mem_read,
    input  logic [AW-1:0]                             ex_dest,
    input  logic                                      me_mem_req,
    input  logic                                      dmem_ready,
    output logic [NUM_SRC*sel_width(FWD_STAGES)-1:0]  fwd_sel,
    output logic                                      stall_front,
    output logic                                      bubble_idex,
    output logic                                      stall_all,
    output logic                                      mem_timeout,
    output logic [CNT_W-1:0]                          stall_count
);

    localparam int SW  = sel_width(FWD_STAGES);
    localparam int BW  = $clog2(FWD_STAGES + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    logic [NUM_SRC*SW-1:0] fwd_sel_raw;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_sel_prio #(
            .AW         (AW),
            .FWD_STAGES (FWD_STAGES),
            .SW         (SW)
        ) u_prio (
            .src_addr      (ex_src_addr[i*AW +: AW]),
            .stg_reg_write (stg_reg_write),
            .stg_dest      (stg_dest),
            .sel           (fwd_sel_raw[i*SW +: SW])
        );
    end

    assign fwd_sel = reset ? '0 : fwd_sel_raw;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic lu_match;
    logic load_use_hit;
    logic mem_block;

    always_comb begin
        lu_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src_addr[i*AW +: AW] == ex_dest)) begin
                lu_match = 1'b1;
            end
        end
    end

    assign load_use_hit = ex_mem_read && (ex_dest != '0) && lu_match;
    assign mem_block    = me_mem_req && !dmem_ready;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    fsm_state_e     state_q, state_d;
    fsm_state_e     ret_q, ret_d;
    logic [BW-1:0]  bub_cnt_q, bub_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic           lu_stall;

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        bub_cnt_d  = bub_cnt_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        lu_stall   = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_block) begin
                    state_d    = MEM_WAIT;
                    ret_d      = RUN;
                    wait_cnt_d = WCW'(1);
                end else if (load_use_hit) begin
                    lu_stall = 1'b1;
                    // The first bubble is this cycle; only extra ones need LU_STALL
                    if (LOAD_FWD_STAGE > 1) begin
                        state_d   = LU_STALL;
                        bub_cnt_d = BW'(LOAD_FWD_STAGE - 1);
                    end
                end
            end

            LU_STALL: begin
                if (mem_block) begin
                    // Remaining bubbles are held until memory completes
                    state_d    = MEM_WAIT;
                    ret_d      = LU_STALL;
                    wait_cnt_d = WCW'(1);
                end else begin
                    lu_stall  = 1'b1;
                    bub_cnt_d = bub_cnt_q - BW'(1);
                    if (bub_cnt_q == BW'(1)) begin
                        state_d = RUN;
                    end
                end
            end

            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ret_q;
                end else begin
                    if (wait_cnt_q == WCW'(TIMEOUT)) begin
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs are forced quiet during the reset cycle
    assign stall_all   = !reset && mem_block;
    assign stall_front = !reset && lu_stall;
    assign bubble_idex = !reset && lu_stall;
    assign mem_timeout = !reset && timeout_q;
    assign stall_count = reset ? '0 : stall_count_q;

    always_comb begin
        stall_count_d = stall_count_q;
        if ((stall_front || stall_all) && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            ret_q         <= RUN;
            bub_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            timeout_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            bub_cnt_q     <= bub_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_q     <= timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Purpose  : Self-checking bench. Two controller instances share stimulus:
//            dut_a (2 stages, 1 load bubble) and dut_b (3 stages, 2 load
//            bubbles); both use a memory timeout of 4 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [9:0]  ex_src_addr;
    logic [2:0]  stg_we;
    logic [14:0] stg_dest;
    logic        ex_mem_read;
    logic [4:0]  ex_dest;
    logic        me_mem_req;
    logic        dmem_ready;

    logic [3:0]  a_sel, b_sel;
    logic        a_sf, a_bub, a_sa, a_to;
    logic        b_sf, b_bub, b_sa, b_to;
    logic [31:0] a_cnt, b_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(
        .AW(5), .NUM_SRC(2), .FWD_STAGES(2), .LOAD_FWD_STAGE(1), .TIMEOUT(4), .CNT_W(32)
    ) dut_a (
        .clk(clk), .reset(reset),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_src_addr(ex_src_addr),
        .stg_reg_write(stg_we[1:0]), .stg_dest(stg_dest[9:0]),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .me_mem_req(me_mem_req), .dmem_ready(dmem_ready),
        .fwd_sel(a_sel), .stall_front(a_sf), .bubble_idex(a_bub),
        .stall_all(a_sa), .mem_timeout(a_to), .stall_count(a_cnt)
    );

    fwd_hazard_ctrl #(
        .AW(5), .NUM_SRC(2), .FWD_STAGES(3), .LOAD_FWD_STAGE(2), .TIMEOUT(4), .CNT_W(32)
    ) dut_b (
        .clk(clk), .reset(reset),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .ex_src_addr(ex_src_addr),
        .stg_reg_write(stg_we), .stg_dest(stg_dest),
        .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
        .me_mem_req(me_mem_req), .dmem_ready(dmem_ready),
        .fwd_sel(b_sel), .stall_front(b_sf), .bubble_idex(b_bub),
        .stall_all(b_sa), .mem_timeout(b_to), .stall_count(b_cnt)
    );

    typedef struct {
        logic [2:0] we;
        logic [4:0] d0, d1, d2, s0, s1;
        logic [1:0] a0, a1, b0, b1;
    } fvec_t;

    fvec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven at posedge+1, outputs checked at posedge+5
    task automatic settle();
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_src_addr = '0; id_src_used = '0; ex_src_addr = '0;
        stg_we = '0; stg_dest = '0;
        ex_mem_read = 1'b0; ex_dest = '0;
        me_mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Load to r3 in EX, ID reading r3 on its second operand
    task automatic load_use();
        ex_mem_read = 1'b1; ex_dest = 5'd3;
        id_src_addr = {5'd3, 5'd0}; id_src_used = 2'b10;
    endtask

    task automatic chk_stall(input string tag, input logic exp_a, input logic exp_b);
        chk({tag, "_a_sf"},  {31'd0, a_sf},  {31'd0, exp_a});
        chk({tag, "_a_bub"}, {31'd0, a_bub}, {31'd0, exp_a});
        chk({tag, "_b_sf"},  {31'd0, b_sf},  {31'd0, exp_b});
        chk({tag, "_b_bub"}, {31'd0, b_bub}, {31'd0, exp_b});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_sel"}, {28'd0, a_sel}, 32'd0);
        chk({tag, "_b_sel"}, {28'd0, b_sel}, 32'd0);
        chk({tag, "_a_flags"}, {28'd0, a_sf, a_bub, a_sa, a_to}, 32'd0);
        chk({tag, "_b_flags"}, {28'd0, b_sf, b_bub, b_sa, b_to}, 32'd0);
        chk({tag, "_a_cnt"}, a_cnt, 32'd0);
        chk({tag, "_b_cnt"}, b_cnt, 32'd0);
    endtask

    initial begin
        //             we      d0     d1     d2     s0     s1     a0  a1  b0  b1
        vt[0] = '{3'b011, 5'd5,  5'd5,  5'd0,  5'd5,  5'd0,  2'd1, 2'd0, 2'd1, 2'd0};
        vt[1] = '{3'b010, 5'd5,  5'd5,  5'd0,  5'd5,  5'd0,  2'd2, 2'd0, 2'd2, 2'd0};
        vt[2] = '{3'b011, 5'd0,  5'd7,  5'd0,  5'd0,  5'd7,  2'd0, 2'd2, 2'd0, 2'd2};
        vt[3] = '{3'b100, 5'd0,  5'd0,  5'd9,  5'd9,  5'd9,  2'd0, 2'd0, 2'd3, 2'd3};
        vt[4] = '{3'b111, 5'd4,  5'd6,  5'd4,  5'd4,  5'd6,  2'd1, 2'd2, 2'd1, 2'd2};
        vt[5] = '{3'b000, 5'd4,  5'd4,  5'd4,  5'd4,  5'd4,  2'd0, 2'd0, 2'd0, 2'd0};
        vt[6] = '{3'b110, 5'd3,  5'd12, 5'd3,  5'd3,  5'd12, 2'd0, 2'd2, 2'd3, 2'd2};
        vt[7] = '{3'b011, 5'd31, 5'd30, 5'd0,  5'd31, 5'd30, 2'd1, 2'd2, 2'd1, 2'd2};
        vt[8] = '{3'b001, 5'd17, 5'd0,  5'd0,  5'd1,  5'd17, 2'd0, 2'd1, 2'd0, 2'd1};

        // ---------------- reset: outputs quiet despite busy inputs ----
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stg_we = 3'b011; stg_dest = {5'd0, 5'd5, 5'd5}; ex_src_addr = {5'd0, 5'd5};
        load_use();
        me_mem_req = 1'b1;
        settle();
        chk_all_zero("reset");
        next_cycle();
        reset = 1'b0;
        idle();
        settle();
        chk_all_zero("post_reset");
        next_cycle();

        // ---------------- forwarding table ----------------
        for (int i = 0; i < 9; i++) begin
            stg_we      = vt[i].we;
            stg_dest    = {vt[i].d2, vt[i].d1, vt[i].d0};
            ex_src_addr = {vt[i].s1, vt[i].s0};
            settle();
            chk($sformatf("fwd%0d_a0", i), {30'd0, a_sel[1:0]}, {30'd0, vt[i].a0});
            chk($sformatf("fwd%0d_a1", i), {30'd0, a_sel[3:2]}, {30'd0, vt[i].a1});
            chk($sformatf("fwd%0d_b0", i), {30'd0, b_sel[1:0]}, {30'd0, vt[i].b0});
            chk($sformatf("fwd%0d_b1", i), {30'd0, b_sel[3:2]}, {30'd0, vt[i].b1});
            next_cycle();
        end
        idle();

        // ---------------- load-use bubbles ----------------
        load_use();
        settle();
        chk_stall("lu1", 1'b1, 1'b1);
        next_cycle();
        idle();
        settle();
        chk_stall("lu2", 1'b0, 1'b1);
        next_cycle();
        settle();
        chk_stall("lu3", 1'b0, 1'b0);
        chk("lu_a_cnt", a_cnt, 32'd1);
        chk("lu_b_cnt", b_cnt, 32'd2);
        next_cycle();

        // Load-use with operand unused, and with load to r0: no stall
        load_use();
        id_src_used = 2'b00;
        settle();
        chk_stall("lu_unused", 1'b0, 1'b0);
        next_cycle();
        load_use();
        ex_dest = 5'd0; id_src_addr = {5'd0, 5'd0}; id_src_used = 2'b11;
        settle();
        chk_stall("lu_r0", 1'b0, 1'b0);
        next_cycle();
        idle();

        // ---------------- memory wait, 3 cycles ----------------
        me_mem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("mw%0d_a_sa", c), {31'd0, a_sa}, 32'd1);
            chk($sformatf("mw%0d_b_sa", c), {31'd0, b_sa}, 32'd1);
            next_cycle();
        end
        dmem_ready = 1'b1;
        settle();
        chk("mw_done_a_sa", {31'd0, a_sa}, 32'd0);
        chk("mw_done_b_sa", {31'd0, b_sa}, 32'd0);
        chk("mw_a_cnt", a_cnt, 32'd4);
        chk("mw_b_cnt", b_cnt, 32'd5);
        chk("mw_a_to", {31'd0, a_to}, 32'd0);
        next_cycle();
        idle();
        settle();
        chk("mw_idle_a_sa", {31'd0, a_sa}, 32'd0);
        next_cycle();

        // ---------------- bubble suspended by a memory wait ----------
        load_use();
        settle();
        chk_stall("sus1", 1'b1, 1'b1);
        next_cycle();
        idle();
        me_mem_req = 1'b1;
        settle();
        chk_stall("sus2", 1'b0, 1'b0);
        chk("sus2_b_sa", {31'd0, b_sa}, 32'd1);
        next_cycle();
        dmem_ready = 1'b1;
        settle();
        chk_stall("sus3", 1'b0, 1'b0);
        chk("sus3_b_sa", {31'd0, b_sa}, 32'd0);
        next_cycle();
        idle();
        settle();
        chk_stall("sus4", 1'b0, 1'b1);
        next_cycle();
        settle();
        chk_stall("sus5", 1'b0, 1'b0);
        chk("sus_a_cnt", a_cnt, 32'd6);
        chk("sus_b_cnt", b_cnt, 32'd8);
        next_cycle();

        // ---------------- timeout (TIMEOUT = 4) ----------------
        me_mem_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            settle();
            chk($sformatf("to%0d_a", c), {31'd0, a_to}, (c >= 6) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d_b", c), {31'd0, b_to}, (c >= 6) ? 32'd1 : 32'd0);
            next_cycle();
        end
        dmem_ready = 1'b1;
        settle();
        chk("to_ready_a", {31'd0, a_to}, 32'd1);
        chk("to_cnt_a", a_cnt, 32'd15);
        chk("to_cnt_b", b_cnt, 32'd17);
        next_cycle();
        idle();
        settle();
        chk("to_sticky_b", {31'd0, b_to}, 32'd1);
        next_cycle();

        // Reset mid-wait clears everything
        me_mem_req = 1'b1;
        next_cycle();
        reset = 1'b1;
        load_use();
        settle();
        chk_all_zero("rst_wait");
        next_cycle();
        reset = 1'b0;
        idle();
        settle();
        chk_all_zero("rst_wait_after");
        next_cycle();

        // ---------------- reset inside LU_STALL ----------------
        load_use();
        settle();
        chk_stall("rlu1", 1'b1, 1'b1);
        next_cycle();
        idle();
        reset = 1'b1;
        settle();
        chk_stall("rlu2", 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        settle();
        chk_stall("rlu3", 1'b0, 1'b0);
        chk("rlu3_b_cnt", b_cnt, 32'd0);
        chk("rlu3_a_cnt", a_cnt, 32'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
